// File: rtl/ping_pong_array.sv
// Multi-channel ping/pong delay responder with a shared saturating pong counter.
// Each channel answers an accepted ping with a one-cycle pong BASE+cfg cycles later.
module ping_pong_array #(
   parameter int unsigned NCH       = 2,
   parameter int unsigned CFGW      = 2,
   parameter int unsigned BASE      = 4,
   parameter int unsigned CW        = 3,
   parameter int unsigned RETRIGGER = 1,
   parameter int unsigned SW        = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH-1:0]       ping,
   input  logic [NCH*CFGW-1:0]  cfg,
   output logic [NCH-1:0]       pong,
   output logic [NCH-1:0]       busy,
   output logic [NCH-1:0]       reject,
   output logic [SW-1:0]        pong_count
);

   localparam int unsigned PW   = $clog2(NCH + 1);
   localparam int unsigned SUMW = SW + PW;
   localparam logic [SUMW-1:0] SAT = SUMW'({SW{1'b1}});

   // Parameter legality: the countdown must hold the largest possible delay.
   if (NCH < 1) begin : g_bad_nch
      $error("ping_pong_array: NCH must be >= 1");
   end
   if (BASE < 1) begin : g_bad_base
      $error("ping_pong_array: BASE must be >= 1");
   end
   if ((2 ** CW) - 1 < BASE + (2 ** CFGW) - 1) begin : g_bad_cw
      $error("ping_pong_array: CW too narrow for BASE + 2^CFGW - 1");
   end

   logic [NCH-1:0][CW-1:0] cnt;
   logic [NCH-1:0][CW-1:0] cnt_next;
   logic [NCH-1:0]         pong_next;
   logic [NCH-1:0]         busy_next;
   logic [NCH-1:0]         reject_next;
   logic [PW-1:0]          pop;
   logic [SUMW-1:0]        sum;
   logic [SW-1:0]          count_next;

   // Per-channel timer: decrement to zero, reload on an accepted ping.
   always_comb begin
      cnt_next    = cnt;
      pong_next   = '0;
      busy_next   = '0;
      reject_next = '0;
      for (int i = 0; i < NCH; i++) begin
         pong_next[i] = (cnt[i] == CW'(1));
         if (cnt[i] != '0) begin
            cnt_next[i] = cnt[i] - CW'(1);
         end
         if (ping[i]) begin
            if ((cnt[i] <= CW'(1)) || (RETRIGGER != 0)) begin
               cnt_next[i] = CW'(BASE) + CW'(cfg[i*CFGW +: CFGW]);
            end else begin
               reject_next[i] = 1'b1;
            end
         end
         busy_next[i] = (cnt_next[i] != '0);
      end
   end

   // Saturating accumulation of the pong vector currently on the outputs.
   always_comb begin
      pop = '0;
      for (int i = 0; i < NCH; i++) begin
         pop = pop + PW'(pong[i]);
      end
      sum = SUMW'(pong_count) + SUMW'(pop);
      if (sum > SAT) begin
         count_next = '1;
      end else begin
         count_next = sum[SW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         pong       <= '0;
         busy       <= '0;
         reject     <= '0;
         pong_count <= '0;
      end else begin
         cnt        <= cnt_next;
         pong       <= pong_next;
         busy       <= busy_next;
         reject     <= reject_next;
         pong_count <= count_next;
      end
   end

endmodule
